alu_serial_ctrl: RTL

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

---
 rtl/alu_serial_ctrl_pkg.sv | 47 ++++
 rtl/alu_top.sv | 33 +++
 rtl/alu_serial_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_serial_ctrl_pkg.sv
// Shared ALU encodings: ctrl codes seen by the CPU decoder, slice op codes and
// serial-controller FSM states.
package alu_serial_ctrl_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic [1:0] op;
  } slice_cfg_t;

  // Per-bit slice controls; unsupported codes fall back to AND (result is forced to 0 later).
  function automatic slice_cfg_t ctrl_decode(input logic [3:0] ctrl);
    slice_cfg_t cfg;
    cfg = '{a_inv: 1'b0, b_inv: 1'b0, op: OP_AND};
    case (ctrl)
      CTRL_OR:  cfg = '{a_inv: 1'b0, b_inv: 1'b0, op: OP_OR};
      CTRL_ADD: cfg = '{a_inv: 1'b0, b_inv: 1'b0, op: OP_ADD};
      CTRL_SUB: cfg = '{a_inv: 1'b0, b_inv: 1'b1, op: OP_ADD};
      CTRL_SLT: cfg = '{a_inv: 1'b0, b_inv: 1'b1, op: OP_LESS};
      CTRL_NOR: cfg = '{a_inv: 1'b1, b_inv: 1'b1, op: OP_AND};
      default:  cfg = '{a_inv: 1'b0, b_inv: 1'b0, op: OP_AND};
    endcase
    return cfg;
  endfunction

  // Initial carry-in: subtract-style operations start with +1.
  function automatic logic ctrl_cin(input logic [3:0] ctrl);
    return (ctrl == CTRL_SUB) || (ctrl == CTRL_SLT);
  endfunction

endpackage

// File: rtl/alu_top.sv
// 1-bit ALU slice: AND / OR / full-add / less-select, with optional operand inversion.
module alu_top
  import alu_serial_ctrl_pkg::*;
(
  input  logic       src1,
  input  logic       src2,
  input  logic       less,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       cin,
  input  logic [1:0] operation,
  output logic       result_c,
  output logic       cout_c,
  output logic       set_c
);

  logic a_eff;
  logic b_eff;

  always_comb begin
    a_eff  = src1 ^ a_invert;
    b_eff  = src2 ^ b_invert;
    set_c  = a_eff ^ b_eff ^ cin;
    cout_c = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);
    case (operation)
      OP_AND:  result_c = a_eff & b_eff;
      OP_OR:   result_c = a_eff | b_eff;
      OP_ADD:  result_c = set_c;
      default: result_c = less;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: runs a WIDTH-bit operation through one alu_top slice,
// LSB first, one bit per clock, and publishes result/flags on completion.
module alu_serial_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);
  import alu_serial_ctrl_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             carry_q, carry_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic             busy_d, done_d, zero_d, cout_d, ovf_d;
  logic [WIDTH-1:0] result_d;

  slice_cfg_t       cfg;
  logic             slice_res, slice_cout, slice_set;
  logic [WIDTH-1:0] fin_res;
  logic             fin_cout, fin_ovf, ovf_raw;
  logic             load;

  assign cfg = ctrl_decode(ctrl_q);

  alu_top u_slice (
    .src1      (a_q[0]),
    .src2      (b_q[0]),
    .less      (1'b0),
    .a_invert  (cfg.a_inv),
    .b_invert  (cfg.b_inv),
    .cin       (carry_q),
    .operation (cfg.op),
    .result_c  (slice_res),
    .cout_c    (slice_cout),
    .set_c     (slice_set)
  );

  // Final result and flags as they stand during the MSB cycle.
  always_comb begin
    ovf_raw  = carry_q ^ slice_cout;
    fin_res  = '0;
    fin_cout = 1'b0;
    fin_ovf  = 1'b0;
    case (ctrl_q)
      CTRL_ADD, CTRL_SUB: begin
        fin_res  = {slice_res, sr_q};
        fin_cout = slice_cout;
        fin_ovf  = ovf_raw;
      end
      CTRL_SLT:                    fin_res = {{(WIDTH-1){1'b0}}, slice_set ^ ovf_raw};
      CTRL_AND, CTRL_OR, CTRL_NOR: fin_res = {slice_res, sr_q};
      default:                     fin_res = '0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    carry_d  = carry_q;
    sr_d     = sr_q;
    busy_d   = busy_o;
    done_d   = 1'b0;
    result_d = result_o;
    zero_d   = zero_o;
    cout_d   = cout_o;
    ovf_d    = overflow_o;
    load     = 1'b0;

    case (state_q)
      ST_IDLE: load = start_i;
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = slice_cout;
        sr_d    = (WIDTH-1)'({slice_res, sr_q} >> 1);
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = fin_res;
          zero_d   = (fin_res == '0);
          cout_d   = fin_cout;
          ovf_d    = fin_ovf;
        end
      end
      ST_DONE: begin
        load    = start_i;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Start only acts outside RUN, so requests during an operation are dropped.
    if (load) begin
      state_d = ST_RUN;
      busy_d  = 1'b1;
      cnt_d   = '0;
      a_d     = src1_i;
      b_d     = src2_i;
      ctrl_d  = ctrl_i;
      carry_d = ctrl_cin(ctrl_i);
      sr_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      carry_q    <= 1'b0;
      sr_q       <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      carry_q    <= carry_d;
      sr_q       <= sr_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      result_o   <= result_d;
      zero_o     <= zero_d;
      cout_o     <= cout_d;
      overflow_o <= ovf_d;
    end
  end

endmodule
